// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
//   Iterative HI/LO multiply/divide unit for MULT, MULTU, DIV and DIVU.
//   One operand bit is processed per clock.  A start accepted in IDLE is
//   followed by WIDTH iteration edges and one fix-up edge, which writes the
//   HI/LO registers and pulses done.  MTHI/MTLO writes are accepted while
//   the unit is idle.
//
//   Build option: define MULT_DIV_DIVIDE_EN to include the divider.  Without
//   it the unit is multiply-only: divide starts are ignored and div_zero is 0.
//
// Ports
//   clk      : clock, rising edge
//   reset    : synchronous, active-high
//   start    : request an operation (sampled only in IDLE)
//   op       : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   op_a     : rs value (multiplicand / dividend)
//   op_b     : ALU-source value (multiplier / divisor)
//   wr_hi    : MTHI strobe
//   wr_lo    : MTLO strobe
//   wr_data  : MTHI/MTLO data
//   busy     : operation in progress
//   done     : one-cycle pulse when HI/LO hold a new result
//   div_zero : sticky, last accepted divide had a zero divisor
//   hi, lo   : HI and LO registers
// ---------------------------------------------------------------------------
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_done;
    logic [WIDTH-1:0]       r_hi;
    logic [WIDTH-1:0]       r_lo;

    // Operand magnitudes; r_b shifts right during multiply, r_a shifts left
    // during divide, so the active bit is always at a fixed position.
    logic [WIDTH-1:0]       r_a;
    logic [WIDTH-1:0]       r_b;
    logic [2*WIDTH-1:0]     r_acc;
    logic                   r_neg_q;

    logic                   w_accept;
    logic signed [WIDTH-1:0] w_a_s;
    logic signed [WIDTH-1:0] w_b_s;
    logic                   w_a_neg;
    logic                   w_b_neg;
    logic [WIDTH-1:0]       w_a_mag;
    logic [WIDTH-1:0]       w_b_mag;
    logic [WIDTH:0]         w_mul_sum;
    logic [2*WIDTH-1:0]     w_mul_acc;
    logic [2*WIDTH-1:0]     w_prod;
    logic [WIDTH-1:0]       w_fin_hi;
    logic [WIDTH-1:0]       w_fin_lo;

`ifdef MULT_DIV_DIVIDE_EN
    logic                   r_is_div;
    logic                   r_neg_r;
    logic [WIDTH-1:0]       r_opa_raw;
    logic                   r_div_zero;
    logic [WIDTH:0]         w_div_shift;
    logic [WIDTH:0]         w_div_trial;
    logic [2*WIDTH-1:0]     w_div_acc;

    assign w_accept = start && (r_state == S_IDLE);
`else
    assign w_accept = start && (r_state == S_IDLE) && !op[1];
`endif

    // Signed ops (op[0]==0) work on magnitudes; signs are restored in FIN.
    assign w_a_s   = op_a;
    assign w_b_s   = op_b;
    assign w_a_neg = !op[0] && (w_a_s < 0);
    assign w_b_neg = !op[0] && (w_b_s < 0);
    assign w_a_mag = w_a_neg ? -op_a : op_a;
    assign w_b_mag = w_b_neg ? -op_b : op_b;

    // Shift-add step: add the multiplicand when the current multiplier bit
    // is set, then shift the accumulator right, keeping the carry.
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_b[0] ? r_a : '0)};
    assign w_mul_acc = {w_mul_sum, r_acc[WIDTH-1:1]};

`ifdef MULT_DIV_DIVIDE_EN
    // Restoring step: the upper half holds the partial remainder, the lower
    // half collects quotient bits.  The remainder stays below the divisor,
    // so the shifted value fits WIDTH+1 bits and the trial fits WIDTH.
    assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_a[WIDTH-1]};
    assign w_div_trial = w_div_shift - {1'b0, r_b};
    assign w_div_acc   = !w_div_trial[WIDTH]
                       ? {w_div_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1}
                       : {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
`endif

    // Final sign fix-up and HI/LO selection.
    always_comb begin
        w_prod   = r_neg_q ? -r_acc : r_acc;
        w_fin_hi = w_prod[2*WIDTH-1:WIDTH];
        w_fin_lo = w_prod[WIDTH-1:0];
`ifdef MULT_DIV_DIVIDE_EN
        if (r_is_div) begin
            if (r_b == '0) begin
                w_fin_lo = '1;
                w_fin_hi = r_opa_raw;
            end else begin
                w_fin_lo = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
                w_fin_hi = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
            end
        end
`endif
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_RUN;
            S_RUN:   if (r_cnt == LAST_ITER) w_state_nxt = S_FIN;
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Control and architectural registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
            r_hi   <= '0;
            r_lo   <= '0;
`ifdef MULT_DIV_DIVIDE_EN
            r_div_zero <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (wr_hi) r_hi <= wr_data;
                    if (wr_lo) r_lo <= wr_data;
                    if (w_accept) begin
                        r_cnt <= '0;
`ifdef MULT_DIV_DIVIDE_EN
                        if (op[1]) r_div_zero <= (op_b == '0);
`endif
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FIN: begin
                    r_hi   <= w_fin_hi;
                    r_lo   <= w_fin_lo;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Operand and accumulator datapath
    always_ff @(posedge clk) begin
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    r_a     <= w_a_mag;
                    r_b     <= w_b_mag;
                    r_acc   <= '0;
                    r_neg_q <= w_a_neg ^ w_b_neg;
`ifdef MULT_DIV_DIVIDE_EN
                    r_is_div  <= op[1];
                    r_neg_r   <= w_a_neg;
                    r_opa_raw <= op_a;
`endif
                end
            end
            S_RUN: begin
`ifdef MULT_DIV_DIVIDE_EN
                if (r_is_div) begin
                    r_acc <= w_div_acc;
                    r_a   <= {r_a[WIDTH-2:0], 1'b0};
                end else begin
                    r_acc <= w_mul_acc;
                    r_b   <= {1'b0, r_b[WIDTH-1:1]};
                end
`else
                r_acc <= w_mul_acc;
                r_b   <= {1'b0, r_b[WIDTH-1:1]};
`endif
            end
            default: ;
        endcase
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;
`ifdef MULT_DIV_DIVIDE_EN
    assign div_zero = r_div_zero;
`else
    assign div_zero = 1'b0;
`endif

endmodule
